dmem_port_arbiter: RTL and testbench

//  Shares the single data-RAM port between the pipeline's memory stage and the

---
 rtl/dmem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares the single data-RAM port between the pipeline memory stage (CPU)
//   and the debug readout requester that dumps RAM words to LED/FND.
//   The CPU always wins the port, except that a pending debug read is forced
//   through after at most MAX_WAIT consecutive busy CPU cycles. In that one
//   forced cycle the CPU access is not served and the pipeline is stalled.
//   A debug read therefore costs the CPU at most one stall cycle, and two
//   stall cycles are never adjacent.
//
// Parameters:
//   AW        RAM byte-address width
//   DW        data width
//   MAX_WAIT  max consecutive CPU-busy cycles a pending debug read waits (>=1)
//
// Ports:
//   i_clk        pipeline clock
//   i_rst        synchronous, active-high reset
//   i_cpu_req    CPU memory access this cycle (load or store)
//   i_cpu_we     CPU store enable (valid with i_cpu_req)
//   i_cpu_addr   CPU byte address
//   i_cpu_wdata  CPU store data
//   o_cpu_rdata  load data to CPU (straight from RAM read data)
//   o_cpu_stall  1 = CPU access not served this cycle, pipeline must hold
//   i_dbg_req    debug read request (level, held until o_dbg_ack)
//   i_dbg_addr   debug word index (byte address = i_dbg_addr << 2)
//   o_dbg_ack    one-cycle pulse, o_dbg_rdata is valid
//   o_dbg_rdata  registered debug read data, held until the next ack
//   o_ram_addr   RAM byte address
//   o_ram_we     RAM write enable
//   o_ram_wdata  RAM write data
//   i_ram_rdata  RAM read data (asynchronous read, same cycle as o_ram_addr)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_stall,
  input  logic          i_dbg_req,
  input  logic [AW-1:0] i_dbg_addr,
  output logic          o_dbg_ack,
  output logic [DW-1:0] o_dbg_rdata,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata
);

  // Wait counter only has to reach MAX_WAIT-1; keep at least one bit so the
  // MAX_WAIT=1 configuration still elaborates.
  localparam int unsigned     CW           = (MAX_WAIT > 32'd1) ? $clog2(MAX_WAIT) : 32'd1;
  localparam logic [CW-1:0]   LP_WAIT_LAST = CW'(MAX_WAIT - 32'd1);
  localparam logic [CW-1:0]   LP_CNT_ZERO  = CW'(32'd0);
  localparam logic [CW-1:0]   LP_CNT_ONE   = CW'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no debug activity
    ST_PEND  = 2'd1,  // debug read waiting for a free port (or for the timeout)
    ST_GRANT = 2'd2,  // debug read owns the RAM port this cycle
    ST_DONE  = 2'd3   // read delivered, waiting for the requester to drop dbg_req
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_wait_cnt;
  logic [CW-1:0]   w_wait_cnt_nxt;
  logic            r_dbg_ack;
  logic [DW-1:0]   r_dbg_rdata;
  logic            w_grant;
  logic [AW-1:0]   w_dbg_byte_addr;

  // Word index to byte address; bits shifted out at the top are simply lost
  // (no range check, the address wraps inside the AW-bit space).
  assign w_dbg_byte_addr = i_dbg_addr << 2;

  assign w_grant = (r_state == ST_GRANT);

  // Next-state and wait-counter logic of the debug arbitration FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        w_wait_cnt_nxt = LP_CNT_ZERO;
        if (i_dbg_req) begin
          w_state_nxt = ST_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!i_dbg_req) begin
          // Requester gave up before the port was granted: abort quietly.
          w_state_nxt    = ST_IDLE;
          w_wait_cnt_nxt = LP_CNT_ZERO;
        end else if (!i_cpu_req || (r_wait_cnt == LP_WAIT_LAST)) begin
          // Either the CPU leaves the port free, or the debug read has waited
          // its budget and is forced through next cycle.
          w_state_nxt    = ST_GRANT;
          w_wait_cnt_nxt = LP_CNT_ZERO;
        end else begin
          w_state_nxt    = ST_PEND;
          w_wait_cnt_nxt = r_wait_cnt + LP_CNT_ONE;
        end
      end
      ST_GRANT: begin
        // The read completes even if dbg_req drops during this cycle.
        w_state_nxt    = ST_DONE;
        w_wait_cnt_nxt = LP_CNT_ZERO;
      end
      ST_DONE: begin
        // A held request must be dropped before another read is served.
        w_wait_cnt_nxt = LP_CNT_ZERO;
        if (!i_dbg_req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = LP_CNT_ZERO;
      end
    endcase
  end

  // State, wait counter and debug read-data/ack registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= LP_CNT_ZERO;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= {DW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_grant) begin
        r_dbg_rdata <= i_ram_rdata;
        r_dbg_ack   <= 1'b1;
      end else begin
        r_dbg_ack   <= 1'b0;
      end
    end
  end

  // RAM port steering and CPU stall. Reset overrides the FSM so that a
  // reset landing in GRANT neither stalls the CPU nor writes the RAM.
  always_comb begin
    o_ram_addr  = i_cpu_addr;
    o_ram_we    = 1'b0;
    o_ram_wdata = i_cpu_wdata;
    o_cpu_stall = 1'b0;
    if (i_rst) begin
      o_ram_addr  = i_cpu_addr;
      o_ram_we    = 1'b0;
      o_cpu_stall = 1'b0;
    end else if (w_grant) begin
      // Debug read owns the port; an access the CPU presents now is held
      // by the pipeline and re-presented next cycle.
      o_ram_addr  = w_dbg_byte_addr;
      o_ram_we    = 1'b0;
      o_cpu_stall = i_cpu_req;
    end else begin
      o_ram_addr  = i_cpu_addr;
      o_ram_we    = i_cpu_req & i_cpu_we;
      o_cpu_stall = 1'b0;
    end
  end

  assign o_cpu_rdata = i_ram_rdata;
  assign o_dbg_ack   = r_dbg_ack;
  assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter with a small asynchronous-read RAM
// behind the arbiter and a golden copy of the RAM kept by the bench.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem  [256];
  logic [DW-1:0] gold [256];
  int            wr_cnt [256];

  int n_checks;
  int n_errors;
  int idx;
  int stalls;
  int acks;
  int diff;

  dmem_port_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_stall (cpu_stall),
    .i_dbg_req   (dbg_req),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_ack   (dbg_ack),
    .o_dbg_rdata (dbg_rdata),
    .o_ram_addr  (ram_addr),
    .o_ram_we    (ram_we),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: asynchronous read, synchronous write, per-word write counter.
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[9:2]]    <= ram_wdata;
      wr_cnt[ram_addr[9:2]] <= wr_cnt[ram_addr[9:2]] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int w, input logic [DW-1:0] v);
    mem[w]  = v;
    gold[w] = v;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h0;
      gold[i]   = 32'h0;
      wr_cnt[i] = 0;
    end
    rst       = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h20;
    cpu_wdata = 32'h0BAD_0BAD;
    dbg_req   = 1'b0;
    dbg_addr  = 32'h0;
    tick();
    tick();
    // Reset: registered outputs cleared, no write and no stall while rst.
    check_eq("rst_ram_we", {63'd0, ram_we}, 64'd0);
    check_eq("rst_stall", {63'd0, cpu_stall}, 64'd0);
    check_eq("rst_ack", {63'd0, dbg_ack}, 64'd0);
    check_eq("rst_rdata", {32'd0, dbg_rdata}, 64'd0);

    // 1: CPU store then load, no debug traffic.
    rst       = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h10;
    cpu_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("t1_st_we", {63'd0, ram_we}, 64'd1);
    check_eq("t1_st_addr", {32'd0, ram_addr}, 64'h10);
    check_eq("t1_st_stall", {63'd0, cpu_stall}, 64'd0);
    gold[4] = 32'hDEAD_BEEF;
    tick();
    cpu_we = 1'b0;
    #1;
    check_eq("t1_ld_we", {63'd0, ram_we}, 64'd0);
    check_eq("t1_ld_data", {32'd0, cpu_rdata}, 64'hDEAD_BEEF);
    check_eq("t1_ld_stall", {63'd0, cpu_stall}, 64'd0);
    tick();
    cpu_req = 1'b0;

    // 2: idle CPU, debug read of word 2 (byte 0x8).
    preload(2, 32'h0000_1234);
    cpu_addr = 32'h40;
    dbg_req  = 1'b1;
    dbg_addr = 32'h2;
    tick();                                  // IDLE -> PEND
    check_eq("t2_pend_addr", {32'd0, ram_addr}, 64'h40);
    check_eq("t2_pend_ack", {63'd0, dbg_ack}, 64'd0);
    tick();                                  // PEND -> GRANT
    check_eq("t2_gnt_addr", {32'd0, ram_addr}, 64'h8);
    check_eq("t2_gnt_we", {63'd0, ram_we}, 64'd0);
    check_eq("t2_gnt_stall", {63'd0, cpu_stall}, 64'd0);
    check_eq("t2_gnt_ack", {63'd0, dbg_ack}, 64'd0);
    tick();                                  // GRANT -> DONE
    check_eq("t2_ack", {63'd0, dbg_ack}, 64'd1);
    check_eq("t2_rdata", {32'd0, dbg_rdata}, 64'h1234);

    // 4: held request gets no second read; drop and raise gets a new one.
    preload(3, 32'h5555_AAAA);
    dbg_addr = 32'h3;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t4_held_ack", {63'd0, dbg_ack}, 64'd0);
      check_eq("t4_held_addr", {32'd0, ram_addr}, 64'h40);
    end
    dbg_req = 1'b0;
    tick();                                  // DONE -> IDLE
    dbg_req = 1'b1;
    tick();                                  // IDLE -> PEND
    tick();                                  // PEND -> GRANT
    check_eq("t4_gnt_addr", {32'd0, ram_addr}, 64'hC);
    tick();
    check_eq("t4_ack", {63'd0, dbg_ack}, 64'd1);
    check_eq("t4_rdata", {32'd0, dbg_rdata}, 64'h5555_AAAA);
    dbg_req = 1'b0;
    tick();

    // 3: CPU busy every cycle; debug read forced through after MAX_WAIT cycles.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h10;
    dbg_req  = 1'b1;
    dbg_addr = 32'h2;
    tick();                                  // PEND entered, cycle 1 follows
    for (int c = 1; c <= 8; c++) begin
      check_eq("t3_stall", {63'd0, cpu_stall}, (c == MAX_WAIT + 1) ? 64'd1 : 64'd0);
      check_eq("t3_ack", {63'd0, dbg_ack}, (c == MAX_WAIT + 2) ? 64'd1 : 64'd0);
      if (c == MAX_WAIT + 2) begin
        check_eq("t3_rdata", {32'd0, dbg_rdata}, 64'h1234);
        check_eq("t3_cpu_ld", {32'd0, cpu_rdata}, 64'hDEAD_BEEF);
      end
      tick();
    end
    dbg_req = 1'b0;
    tick();

    // 5a: abort in PEND -> no ack, no stall.
    dbg_req = 1'b1;
    tick();                                  // PEND cnt 0
    tick();                                  // PEND cnt 1
    dbg_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq("t5_abort_stall", {63'd0, cpu_stall}, 64'd0);
      check_eq("t5_abort_ack", {63'd0, dbg_ack}, 64'd0);
      tick();
    end

    // 5b: reset while in GRANT.
    cpu_req = 1'b0;
    dbg_req = 1'b1;
    dbg_addr = 32'h3;
    tick();                                  // PEND
    tick();                                  // GRANT
    check_eq("t5_gnt_addr", {32'd0, ram_addr}, 64'hC);
    rst     = 1'b1;
    cpu_req = 1'b1;
    #1;
    check_eq("t5_rst_stall", {63'd0, cpu_stall}, 64'd0);
    check_eq("t5_rst_we", {63'd0, ram_we}, 64'd0);
    tick();
    check_eq("t5_rst_ack", {63'd0, dbg_ack}, 64'd0);
    check_eq("t5_rst_rdata", {32'd0, dbg_rdata}, 64'd0);
    dbg_req = 1'b0;
    cpu_req = 1'b0;
    rst     = 1'b0;
    tick();
    check_eq("t5_post_ack", {63'd0, dbg_ack}, 64'd0);

    // 6: debug read in the middle of a store stream; stalled store is re-presented.
    for (int i = 0; i < 256; i++) wr_cnt[i] = 0;
    dbg_req  = 1'b1;
    dbg_addr = 32'h2;
    idx      = 0;
    stalls   = 0;
    acks     = 0;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'((16 + idx) * 4);
      cpu_wdata = 32'hA000_0000 + 32'(idx);
      #1;
      if (dbg_ack) begin
        acks++;
        dbg_req = 1'b0;
      end
      if (cpu_stall) begin
        stalls++;
      end else begin
        gold[16 + idx] = cpu_wdata;
        idx++;
      end
      tick();
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    dbg_req = 1'b0;
    tick();
    check_eq("t6_stores_done", 64'(idx), 64'd8);
    check_eq("t6_stalls", 64'(stalls), 64'd1);
    check_eq("t6_acks", 64'(acks), 64'd1);
    check_eq("t6_rdata", {32'd0, dbg_rdata}, 64'h1234);
    for (int w = 16; w < 24; w++) begin
      check_eq("t6_wr_once", 64'(wr_cnt[w]), 64'd1);
      check_eq("t6_word", {32'd0, mem[w]}, {32'd0, gold[w]});
    end
    diff = 0;
    for (int w = 0; w < 256; w++) begin
      if (mem[w] !== gold[w]) diff++;
    end
    check_eq("t6_ram_golden", 64'(diff), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
